// File: rtl/axi_irq_pkg.sv
// Shared constants, FSM state types and the byte-lane merge helper for the
// AXI interrupt concentrator.
package axi_irq_pkg;

   localparam logic [2:0] REG_RAW     = 3'd0;
   localparam logic [2:0] REG_ENABLE  = 3'd1;
   localparam logic [2:0] REG_EDGE    = 3'd2;
   localparam logic [2:0] REG_INVERT  = 3'd3;
   localparam logic [2:0] REG_PENDING = 3'd4;
   localparam logic [2:0] REG_SWSET   = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} wstate_e;
   typedef enum logic       {R_IDLE, R_DATA}          rstate_e;

   // Replace the byte lanes of old selected by strb with the matching lanes of wd.
   function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  strb);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
      return (old & ~m) | (wd & m);
   endfunction

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: synchroniser, polarity, rising-edge capture and a
// sticky pending bit with software set / write-1-to-clear.
module irq_src_cell
   import axi_irq_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_irq,
   input  logic i_invert,
   input  logic i_edge,
   input  logic i_w1c,
   input  logic i_swset,
   output logic o_raw,
   output logic o_pending
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   sticky_q, sticky_d;
   logic                   s;
   logic                   rise;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], i_irq};
      s        = sync_q[SYNC_STAGES-1] ^ i_invert;
      rise     = i_edge & s & ~prev_q;
      prev_d   = s;
      // A hardware edge in the same cycle as a clear must survive.
      sticky_d = (sticky_q & ~i_w1c) | rise | i_swset;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         prev_q   <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         prev_q   <= prev_d;
         sticky_q <= sticky_d;
      end
   end

   assign o_raw     = s;
   assign o_pending = sticky_q | (~i_edge & s);

endmodule

// File: rtl/axi_irq_concentrator.sv
// AXI4 slave collecting NUM_IRQ interrupt sources into a masked pending vector
// for the core's external interrupt request input.
module axi_irq_concentrator
   import axi_irq_pkg::*;
#(
   parameter int ID_WIDTH    = 6,
   parameter int NUM_IRQ     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_IRQ-1:0]  i_irq,
   output logic [NUM_IRQ-1:0]  o_irq,
   input  logic [ID_WIDTH-1:0] i_awid,
   input  logic [5:0]          i_awaddr,
   input  logic [7:0]          i_awlen,
   input  logic [2:0]          i_awsize,
   input  logic [1:0]          i_awburst,
   input  logic                i_awvalid,
   output logic                o_awready,
   input  logic [63:0]         i_wdata,
   input  logic [7:0]          i_wstrb,
   input  logic                i_wlast,
   input  logic                i_wvalid,
   output logic                o_wready,
   output logic [ID_WIDTH-1:0] o_bid,
   output logic [1:0]          o_bresp,
   output logic                o_bvalid,
   input  logic                i_bready,
   input  logic [ID_WIDTH-1:0] i_arid,
   input  logic [5:0]          i_araddr,
   input  logic [7:0]          i_arlen,
   input  logic [2:0]          i_arsize,
   input  logic [1:0]          i_arburst,
   input  logic                i_arvalid,
   output logic                o_arready,
   output logic [ID_WIDTH-1:0] o_rid,
   output logic [63:0]         o_rdata,
   output logic [1:0]          o_rresp,
   output logic                o_rlast,
   output logic                o_rvalid,
   input  logic                i_rready
);

   logic [NUM_IRQ-1:0]  enable_q, enable_d;
   logic [NUM_IRQ-1:0]  edge_q, edge_d;
   logic [NUM_IRQ-1:0]  invert_q, invert_d;
   logic [NUM_IRQ-1:0]  irq_q, irq_d;
   logic [NUM_IRQ-1:0]  w1c, swset, raw, pending;
   logic [NUM_IRQ-1:0]  rd_reg;
   logic [31:0]         en_m, edge_m, inv_m, set_m;
   logic                wr_commit;
   logic [2:0]          wr_sel;

   wstate_e             wstate_q;
   logic                bvalid_q;
   logic [1:0]          bresp_q;
   logic [ID_WIDTH-1:0] bid_q;

   rstate_e             rstate_q;
   logic                rvalid_q, rlast_q;
   logic [1:0]          rresp_q;
   logic [63:0]         rdata_q;
   logic [ID_WIDTH-1:0] rid_q;
   logic [7:0]          rlen_q, rcnt_q;

   logic                unused_ok;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
      irq_src_cell #(.SYNC_STAGES(SYNC_STAGES)) u_cell (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_irq     (i_irq[g]),
         .i_invert  (invert_q[g]),
         .i_edge    (edge_q[g]),
         .i_w1c     (w1c[g]),
         .i_swset   (swset[g]),
         .o_raw     (raw[g]),
         .o_pending (pending[g])
      );
   end

   assign o_awready = (wstate_q == W_IDLE) & i_awvalid & i_wvalid;
   assign o_wready  = o_awready | (wstate_q == W_BURST);
   // Only single-beat writes touch registers; the first beat of a burst is dropped.
   assign wr_commit = o_awready & (i_awlen == 8'd0);
   assign wr_sel    = i_awaddr[5:3];

   assign en_m   = strb_merge(32'(enable_q), i_wdata[31:0], i_wstrb[3:0]);
   assign edge_m = strb_merge(32'(edge_q),   i_wdata[31:0], i_wstrb[3:0]);
   assign inv_m  = strb_merge(32'(invert_q), i_wdata[31:0], i_wstrb[3:0]);
   assign set_m  = strb_merge(32'h0,         i_wdata[31:0], i_wstrb[3:0]);

   always_comb begin
      enable_d = enable_q;
      edge_d   = edge_q;
      invert_d = invert_q;
      w1c      = '0;
      swset    = '0;
      if (wr_commit) begin
         case (wr_sel)
            REG_ENABLE:  enable_d = en_m[NUM_IRQ-1:0];
            REG_EDGE:    edge_d   = edge_m[NUM_IRQ-1:0];
            REG_INVERT:  invert_d = inv_m[NUM_IRQ-1:0];
            REG_PENDING: w1c      = set_m[NUM_IRQ-1:0];
            REG_SWSET:   swset    = set_m[NUM_IRQ-1:0];
            default:     ;
         endcase
      end
      irq_d = pending & enable_q;
   end

   always_comb begin
      rd_reg = '0;
      case (i_araddr[5:3])
         REG_RAW:     rd_reg = raw;
         REG_ENABLE:  rd_reg = enable_q;
         REG_EDGE:    rd_reg = edge_q;
         REG_INVERT:  rd_reg = invert_q;
         REG_PENDING: rd_reg = pending;
         default:     rd_reg = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_q <= '0;
         edge_q   <= '0;
         invert_q <= '0;
         irq_q    <= '0;
      end else begin
         enable_q <= enable_d;
         edge_q   <= edge_d;
         invert_q <= invert_d;
         irq_q    <= irq_d;
      end
   end

   // Write channel: joint AW/W accept, burst drain, response hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wstate_q <= W_IDLE;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         bid_q    <= '0;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (i_awvalid && i_wvalid) begin
                  bid_q <= i_awid;
                  if (i_awlen == 8'd0) begin
                     bresp_q  <= RESP_OKAY;
                     bvalid_q <= 1'b1;
                     wstate_q <= W_RESP;
                  end else if (i_wlast) begin
                     bresp_q  <= RESP_SLVERR;
                     bvalid_q <= 1'b1;
                     wstate_q <= W_RESP;
                  end else begin
                     bresp_q  <= RESP_SLVERR;
                     wstate_q <= W_BURST;
                  end
               end
            end
            W_BURST: begin
               if (i_wvalid && i_wlast) begin
                  bvalid_q <= 1'b1;
                  wstate_q <= W_RESP;
               end
            end
            W_RESP: begin
               if (i_bready) begin
                  bvalid_q <= 1'b0;
                  wstate_q <= W_IDLE;
               end
            end
            default: wstate_q <= W_IDLE;
         endcase
      end
   end

   // Read channel: data is captured at address accept, so it is the pre-write value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rstate_q <= R_IDLE;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
         rid_q    <= '0;
         rlen_q   <= '0;
         rcnt_q   <= '0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (i_arvalid) begin
                  rid_q    <= i_arid;
                  rlen_q   <= i_arlen;
                  rcnt_q   <= '0;
                  rvalid_q <= 1'b1;
                  rstate_q <= R_DATA;
                  if (i_arlen == 8'd0) begin
                     rdata_q <= 64'(rd_reg);
                     rresp_q <= RESP_OKAY;
                     rlast_q <= 1'b1;
                  end else begin
                     rdata_q <= '0;
                     rresp_q <= RESP_SLVERR;
                     rlast_q <= 1'b0;
                  end
               end
            end
            R_DATA: begin
               if (i_rready) begin
                  if (rlast_q) begin
                     rvalid_q <= 1'b0;
                     rlast_q  <= 1'b0;
                     rstate_q <= R_IDLE;
                  end else begin
                     rcnt_q  <= rcnt_q + 8'd1;
                     rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                  end
               end
            end
            default: rstate_q <= R_IDLE;
         endcase
      end
   end

   assign o_irq     = irq_q;
   assign o_bvalid  = bvalid_q;
   assign o_bresp   = bresp_q;
   assign o_bid     = bid_q;
   assign o_arready = (rstate_q == R_IDLE) & i_arvalid;
   assign o_rvalid  = rvalid_q;
   assign o_rlast   = rlast_q;
   assign o_rresp   = rresp_q;
   assign o_rdata   = rdata_q;
   assign o_rid     = rid_q;

   assign unused_ok = ^{i_awsize, i_awburst, i_arsize, i_arburst, i_wdata[63:32],
                        i_wstrb[7:4], i_awaddr[2:0], i_araddr[2:0],
                        en_m, edge_m, inv_m, set_m};

endmodule

// File: tb/tb_axi_irq_concentrator.sv
// Directed bench for axi_irq_concentrator: register map, level/edge capture,
// polarity, sticky set/clear races, bursts and response back-pressure.
module tb_axi_irq_concentrator;

   localparam int ID_WIDTH    = 6;
   localparam int NUM_IRQ     = 8;
   localparam int SYNC_STAGES = 2;

   localparam logic [5:0] A_RAW     = 6'h00;
   localparam logic [5:0] A_ENABLE  = 6'h08;
   localparam logic [5:0] A_EDGE    = 6'h10;
   localparam logic [5:0] A_INVERT  = 6'h18;
   localparam logic [5:0] A_PENDING = 6'h20;
   localparam logic [5:0] A_SWSET   = 6'h28;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NUM_IRQ-1:0]  i_irq = '0;
   logic [NUM_IRQ-1:0]  o_irq;
   logic [ID_WIDTH-1:0] i_awid = '0;
   logic [5:0]          i_awaddr = '0;
   logic [7:0]          i_awlen = '0;
   logic [2:0]          i_awsize = '0;
   logic [1:0]          i_awburst = '0;
   logic                i_awvalid = 1'b0;
   logic                o_awready;
   logic [63:0]         i_wdata = '0;
   logic [7:0]          i_wstrb = '0;
   logic                i_wlast = 1'b0;
   logic                i_wvalid = 1'b0;
   logic                o_wready;
   logic [ID_WIDTH-1:0] o_bid;
   logic [1:0]          o_bresp;
   logic                o_bvalid;
   logic                i_bready = 1'b0;
   logic [ID_WIDTH-1:0] i_arid = '0;
   logic [5:0]          i_araddr = '0;
   logic [7:0]          i_arlen = '0;
   logic [2:0]          i_arsize = '0;
   logic [1:0]          i_arburst = '0;
   logic                i_arvalid = 1'b0;
   logic                o_arready;
   logic [ID_WIDTH-1:0] o_rid;
   logic [63:0]         o_rdata;
   logic [1:0]          o_rresp;
   logic                o_rlast;
   logic                o_rvalid;
   logic                i_rready = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   axi_irq_concentrator #(
      .ID_WIDTH(ID_WIDTH), .NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_irq(i_irq), .o_irq(o_irq),
      .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
      .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
      .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
      .o_wready(o_wready), .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid),
      .i_bready(i_bready), .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen),
      .i_arsize(i_arsize), .i_arburst(i_arburst), .i_arvalid(i_arvalid),
      .o_arready(o_arready), .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp),
      .o_rlast(o_rlast), .o_rvalid(o_rvalid), .i_rready(i_rready)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                            input logic [7:0] s, output logic [1:0] resp);
      int n;
      i_awid = 6'h01; i_awaddr = a; i_awlen = 8'd0; i_awsize = 3'd3; i_awburst = 2'd1;
      i_wdata = {32'hDEAD_BEEF, d}; i_wstrb = s; i_wlast = 1'b1;
      i_awvalid = 1'b1; i_wvalid = 1'b1;
      #1;
      n = 0;
      while (!(o_awready && o_wready) && n < 20) begin tick(1); n++; end
      tests++;
      if (n >= 20) begin fails++; $display("FAIL wr_accept addr=%h: no awready/wready in 20 cycles", a); end
      tick(1);
      i_awvalid = 1'b0; i_wvalid = 1'b0; i_wlast = 1'b0; i_bready = 1'b1;
      n = 0;
      while (!o_bvalid && n < 20) begin tick(1); n++; end
      tests++;
      if (n >= 20) begin fails++; $display("FAIL wr_resp addr=%h: no bvalid in 20 cycles", a); end
      resp = o_bresp;
      tick(1);
      i_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [5:0] a, output logic [63:0] d, output logic [1:0] resp);
      int n;
      i_arid = 6'h03; i_araddr = a; i_arlen = 8'd0; i_arsize = 3'd3; i_arburst = 2'd1;
      i_arvalid = 1'b1;
      #1;
      n = 0;
      while (!o_arready && n < 20) begin tick(1); n++; end
      tests++;
      if (n >= 20) begin fails++; $display("FAIL rd_accept addr=%h: no arready in 20 cycles", a); end
      tick(1);
      i_arvalid = 1'b0; i_rready = 1'b1;
      n = 0;
      while (!o_rvalid && n < 20) begin tick(1); n++; end
      tests++;
      if (n >= 20) begin fails++; $display("FAIL rd_resp addr=%h: no rvalid in 20 cycles", a); end
      d = o_rdata; resp = o_rresp;
      tick(1);
      i_rready = 1'b0;
   endtask

   task automatic test_reset();
      logic [63:0] d;
      logic [1:0]  r;
      rst_n = 1'b0;
      tick(3);
      tests++;
      if ({o_irq, o_bvalid, o_rvalid, o_awready, o_wready, o_arready} !== '0) begin
         fails++;
         $display("FAIL reset_ctrl: irq=%h bv=%b rv=%b awr=%b wr=%b arr=%b, required all 0",
                  o_irq, o_bvalid, o_rvalid, o_awready, o_wready, o_arready);
      end
      tests++;
      if ({o_bresp, o_rresp, o_rdata} !== '0) begin
         fails++;
         $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h, required 0", o_bresp, o_rresp, o_rdata);
      end
      rst_n = 1'b1;
      tick(2);
      for (int i = 0; i < 8; i++) begin
         axi_read(6'(i * 8), d, r);
         tests++;
         if ({r, d} !== 66'h0) begin
            fails++;
            $display("FAIL reset_reg%0d: rdata=%h rresp=%b, required 0 OKAY", i, d, r);
         end
      end
   endtask

   task automatic test_level();
      logic [63:0] d;
      logic [1:0]  r;
      axi_write(A_ENABLE, 32'h0000_00FF, 8'h0F, r);
      tests++;
      if (r !== 2'b00) begin fails++; $display("FAIL enable_bresp: got %b, required 00", r); end
      axi_write(A_EDGE, 32'h0, 8'h0F, r);
      i_irq = 8'h04;
      tick(2);
      tests++;
      if (o_irq !== 8'h00) begin fails++; $display("FAIL level_early: o_irq=%h, required 00", o_irq); end
      tick(1);
      tests++;
      if (o_irq !== 8'h04) begin fails++; $display("FAIL level_rise: o_irq=%h, required 04", o_irq); end
      i_irq = 8'h00;
      tick(2);
      tests++;
      if (o_irq !== 8'h04) begin fails++; $display("FAIL level_fall_early: o_irq=%h, required 04", o_irq); end
      tick(1);
      tests++;
      if (o_irq !== 8'h00) begin fails++; $display("FAIL level_fall: o_irq=%h, required 00", o_irq); end
      i_irq = 8'h04;
      tick(4);
      axi_write(A_PENDING, 32'h04, 8'h01, r);
      axi_read(A_PENDING, d, r);
      tests++;
      if (d !== 64'h04) begin fails++; $display("FAIL level_w1c: pending=%h, required 04", d); end
      i_irq = 8'h00;
      tick(4);
      axi_read(A_PENDING, d, r);
      tests++;
      if (d !== 64'h00) begin fails++; $display("FAIL level_release: pending=%h, required 00", d); end
      axi_write(A_ENABLE, 32'h0, 8'hF0, r);
      axi_read(A_ENABLE, d, r);
      tests++;
      if (d !== 64'hFF) begin fails++; $display("FAIL strb_mask: enable=%h, required ff", d); end
   endtask

   task automatic test_edge();
      logic [63:0] d;
      logic [1:0]  r;
      axi_write(A_EDGE, 32'h01, 8'h0F, r);
      i_irq = 8'h01;
      tick(1);
      i_irq = 8'h00;
      tick(2);
      tests++;
      if (o_irq !== 8'h00) begin fails++; $display("FAIL edge_early: o_irq=%h, required 00", o_irq); end
      tick(1);
      tests++;
      if (o_irq !== 8'h01) begin fails++; $display("FAIL edge_irq: o_irq=%h, required 01", o_irq); end
      axi_read(A_PENDING, d, r);
      tests++;
      if (d !== 64'h01) begin fails++; $display("FAIL edge_sticky: pending=%h, required 01", d); end
      axi_write(A_PENDING, 32'h01, 8'h01, r);
      tests++;
      if (o_irq !== 8'h00) begin fails++; $display("FAIL edge_w1c: o_irq=%h, required 00", o_irq); end
      // Second pulse: its capture edge coincides with the W1C commit edge.
      i_irq = 8'h01;
      tick(1);
      i_irq = 8'h00;
      tick(1);
      i_awid = 6'h01; i_awaddr = A_PENDING; i_awlen = 8'd0; i_wdata = 64'h1;
      i_wstrb = 8'h01; i_wlast = 1'b1; i_awvalid = 1'b1; i_wvalid = 1'b1;
      #1;
      tests++;
      if (!(o_awready && o_wready)) begin
         fails++;
         $display("FAIL race_accept: awready=%b wready=%b, required 1 1", o_awready, o_wready);
      end
      tick(1);
      i_awvalid = 1'b0; i_wvalid = 1'b0; i_wlast = 1'b0; i_bready = 1'b1;
      tick(1);
      i_bready = 1'b0;
      axi_read(A_PENDING, d, r);
      tests++;
      if (d !== 64'h01) begin fails++; $display("FAIL set_wins: pending=%h, required 01", d); end
      axi_write(A_PENDING, 32'h01, 8'h01, r);
   endtask

   task automatic test_invert_swset();
      logic [63:0] d;
      logic [1:0]  r;
      axi_write(A_INVERT, 32'h80, 8'h0F, r);
      axi_read(A_RAW, d, r);
      tests++;
      if (d !== 64'h80) begin fails++; $display("FAIL invert_raw: raw=%h, required 80", d); end
      axi_write(A_EDGE, 32'hFFFF_FFC0, 8'h0F, r);
      axi_read(A_EDGE, d, r);
      tests++;
      if (d !== 64'hC0) begin fails++; $display("FAIL edge_width: edge=%h, required c0", d); end
      axi_write(A_SWSET, 32'h40, 8'h01, r);
      axi_read(A_PENDING, d, r);
      tests++;
      if (d !== 64'h40) begin fails++; $display("FAIL swset_pending: pending=%h, required 40", d); end
      axi_read(A_SWSET, d, r);
      tests++;
      if ({r, d} !== 66'h0) begin fails++; $display("FAIL swset_read: rdata=%h rresp=%b, required 0 OKAY", d, r); end
      axi_read(A_RAW, d, r);
      tests++;
      if (d !== 64'h80) begin fails++; $display("FAIL swset_raw: raw=%h, required 80", d); end
      axi_write(A_INVERT, 32'h00, 8'h0F, r);
      axi_write(A_INVERT, 32'h80, 8'h0F, r);
      axi_read(A_PENDING, d, r);
      tests++;
      if (d !== 64'hC0) begin fails++; $display("FAIL invert_edge: pending=%h, required c0", d); end
      tests++;
      if (o_irq !== 8'hC0) begin fails++; $display("FAIL invert_irq: o_irq=%h, required c0", o_irq); end
      axi_write(A_PENDING, 32'hC0, 8'h01, r);
      axi_read(A_PENDING, d, r);
      tests++;
      if (d !== 64'h00) begin fails++; $display("FAIL clear_c0: pending=%h, required 00", d); end
   endtask

   task automatic test_burst();
      logic [63:0] d;
      logic [1:0]  r;
      int          beats;
      int          bad;
      int          n;
      i_awid = 6'h2A; i_awaddr = A_ENABLE; i_awlen = 8'd3; i_wdata = 64'h0;
      i_wstrb = 8'hFF; i_wlast = 1'b0; i_awvalid = 1'b1; i_wvalid = 1'b1;
      beats = 0;
      for (int b = 0; b < 4; b++) begin
         i_wlast = (b == 3);
         #1;
         n = 0;
         while (!o_wready && n < 10) begin tick(1); n++; end
         if (o_wready) beats++;
         tick(1);
         i_awvalid = 1'b0;
      end
      i_wvalid = 1'b0; i_wlast = 1'b0;
      tests++;
      if (beats !== 4) begin fails++; $display("FAIL burst_beats: accepted %0d, required 4", beats); end
      tests++;
      if ({o_bvalid, o_bresp, o_bid} !== {1'b1, 2'b10, 6'h2A}) begin
         fails++;
         $display("FAIL burst_bresp: bvalid=%b bresp=%b bid=%h, required 1 10 2a", o_bvalid, o_bresp, o_bid);
      end
      i_awid = 6'h11; i_awlen = 8'd0; i_wlast = 1'b1; i_awvalid = 1'b1; i_wvalid = 1'b1;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (!o_bvalid || o_bid !== 6'h2A || o_bresp !== 2'b10 || o_awready) bad++;
         tick(1);
      end
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL bstall: %0d bad cycles, required 0", bad); end
      i_awvalid = 1'b0; i_wvalid = 1'b0; i_wlast = 1'b0; i_bready = 1'b1;
      tick(1);
      i_bready = 1'b0;
      tests++;
      if (o_bvalid !== 1'b0) begin fails++; $display("FAIL bdone: bvalid=%b, required 0", o_bvalid); end
      axi_read(A_ENABLE, d, r);
      tests++;
      if (d !== 64'hFF) begin fails++; $display("FAIL burst_nowrite: enable=%h, required ff", d); end
      i_arid = 6'h15; i_araddr = A_ENABLE; i_arlen = 8'd2; i_arvalid = 1'b1;
      #1;
      n = 0;
      while (!o_arready && n < 10) begin tick(1); n++; end
      tick(1);
      i_arvalid = 1'b0; i_rready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         n = 0;
         while (!o_rvalid && n < 10) begin tick(1); n++; end
         tests++;
         if ({o_rvalid, o_rdata, o_rresp, o_rlast, o_rid} !== {1'b1, 64'h0, 2'b10, (b == 2), 6'h15}) begin
            fails++;
            $display("FAIL rburst_beat%0d: rv=%b rdata=%h rresp=%b rlast=%b rid=%h, required 1 0 10 %0d 15",
                     b, o_rvalid, o_rdata, o_rresp, o_rlast, o_rid, (b == 2));
         end
         tick(1);
      end
      i_rready = 1'b0;
      tests++;
      if (o_rvalid !== 1'b0) begin fails++; $display("FAIL rburst_end: rvalid=%b, required 0", o_rvalid); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] d;
      logic [1:0]  r;
      int          bad;
      i_awid = 6'h07; i_awaddr = A_ENABLE; i_awlen = 8'd0; i_wdata = 64'h3C;
      i_wstrb = 8'h0F; i_wlast = 1'b1; i_awvalid = 1'b1; i_wvalid = 1'b1;
      i_arid = 6'h09; i_araddr = A_ENABLE; i_arlen = 8'd0; i_arvalid = 1'b1;
      #1;
      tests++;
      if (!(o_awready && o_wready && o_arready)) begin
         fails++;
         $display("FAIL b2b_accept: awr=%b wr=%b arr=%b, required 1 1 1", o_awready, o_wready, o_arready);
      end
      tick(1);
      i_wdata = 64'h55; i_araddr = A_RAW;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (!o_bvalid || o_bid !== 6'h07 || !o_rvalid || o_rdata !== 64'hFF || o_rid !== 6'h09 ||
             o_rresp !== 2'b00 || !o_rlast || o_awready || o_arready) bad++;
         tick(1);
      end
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL b2b_stall: %0d bad cycles (rdata=%h), required 0 (ff)", bad, o_rdata); end
      i_awvalid = 1'b0; i_wvalid = 1'b0; i_wlast = 1'b0; i_arvalid = 1'b0;
      i_bready = 1'b1; i_rready = 1'b1;
      tick(1);
      i_bready = 1'b0; i_rready = 1'b0;
      tests++;
      if ({o_bvalid, o_rvalid} !== 2'b00) begin
         fails++;
         $display("FAIL b2b_done: bvalid=%b rvalid=%b, required 0 0", o_bvalid, o_rvalid);
      end
      axi_read(A_ENABLE, d, r);
      tests++;
      if (d !== 64'h3C) begin fails++; $display("FAIL b2b_write: enable=%h, required 3c", d); end
   endtask

   task automatic test_reset_abort();
      logic [63:0] d;
      logic [1:0]  r;
      axi_write(A_SWSET, 32'h04, 8'h01, r);
      tests++;
      if (o_irq !== 8'h04) begin fails++; $display("FAIL abort_pre_irq: o_irq=%h, required 04", o_irq); end
      i_awid = 6'h01; i_awaddr = A_ENABLE; i_awlen = 8'd0; i_wdata = 64'h01;
      i_wstrb = 8'h0F; i_wlast = 1'b1; i_awvalid = 1'b1; i_wvalid = 1'b1;
      i_arid = 6'h02; i_araddr = A_ENABLE; i_arlen = 8'd0; i_arvalid = 1'b1;
      tick(1);
      i_awvalid = 1'b0; i_wvalid = 1'b0; i_wlast = 1'b0; i_arvalid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({o_bvalid, o_rvalid, o_irq} !== '0) begin
         fails++;
         $display("FAIL abort_now: bvalid=%b rvalid=%b o_irq=%h, required 0 0 00", o_bvalid, o_rvalid, o_irq);
      end
      tick(2);
      rst_n = 1'b1;
      i_bready = 1'b1; i_rready = 1'b1;
      tick(3);
      tests++;
      if ({o_bvalid, o_rvalid} !== 2'b00) begin
         fails++;
         $display("FAIL abort_after: bvalid=%b rvalid=%b, required 0 0", o_bvalid, o_rvalid);
      end
      i_bready = 1'b0; i_rready = 1'b0;
      axi_read(A_ENABLE, d, r);
      tests++;
      if (d !== 64'h00) begin fails++; $display("FAIL abort_regs: enable=%h, required 00", d); end
   endtask

   initial begin
      test_reset();
      test_level();
      test_edge();
      test_invert_swset();
      test_burst();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axi_irq_concentrator.md
Name: axi_irq_concentrator

Overview:
- Parametrised AXI4 slave that collects NUM_IRQ external and peripheral interrupt sources.
- Replaces the fixed 8-bit extintsrc_req concatenation and the hard-coded sw_irq3/sw_irq4 lines in the SoC toplevel.
- Per source: synchronises the input, applies polarity, selects level or edge capture, holds sticky pending state, masks with an enable.
- Drives a masked vector straight into the core's external interrupt request input. Sits on the interconnect beside multicon and uart.

Parameters:
ID_WIDTH, 6, AXI ID width; matches the LSU bus tag + 2.
NUM_IRQ, 8, number of interrupt sources; legal range 1..32.
SYNC_STAGES, 2, synchroniser depth; legal range 2..3.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_irq  in  NUM_IRQ  raw interrupt sources, asynchronous to clk
o_irq  out  NUM_IRQ  masked pending vector, to the core's extintsrc_req
i_awid/i_awaddr[5:0]/i_awlen[7:0]/i_awsize[2:0]/i_awburst[1:0]/i_awvalid  in  AXI write address
o_awready  out  1  write address accept
i_wdata[63:0]/i_wstrb[7:0]/i_wlast/i_wvalid  in  AXI write data
o_wready  out  1  write data accept
o_bid[ID_WIDTH]/o_bresp[2]/o_bvalid  out  write response; i_bready  in  1
i_arid/i_araddr[5:0]/i_arlen/i_arsize/i_arburst/i_arvalid  in  AXI read address
o_arready  out  1  read address accept
o_rid/o_rdata[64]/o_rresp[2]/o_rlast/o_rvalid  out  read response; i_rready  in  1

Behaviour:
- Reset (async assert, sync deassert handled upstream): every register, synchroniser flop and edge history = 0. o_irq=0, all ready/valid outputs=0, o_bresp=o_rresp=0, o_rdata=0.
- Register map: addr[5:3] selects the register; data in rdata/wdata[31:0]; [63:32] reads 0. Bits >= NUM_IRQ read 0 and ignore writes.
  - 0 RAW: RO, synchronised input after polarity.
  - 1 ENABLE: RW.
  - 2 EDGE: RW; 1=edge, 0=level.
  - 3 INVERT: RW; 1=active-low source.
  - 4 PENDING: RO value; write-1-to-clear of sticky bits.
  - 5 SWSET: write-1 sets sticky; reads 0.
  - 6,7: reads 0 OKAY; writes ignored OKAY.
- Writes are byte-masked by wstrb[3:0].
- Source path per bit:
  - s = sync(i_irq) XOR INVERT.
  - In edge mode, a rising s (prev=0, now=1) sets sticky.
  - pending = sticky | (~EDGE & s).
  - o_irq = registered (pending & ENABLE); one cycle after PENDING/ENABLE change.
  - Input-to-o_irq latency = SYNC_STAGES+1 cycles (level) or SYNC_STAGES+2 cycles (edge).
- Simultaneous events:
  - Hardware edge set and W1C on the same bit in the same cycle: set wins.
  - A level source stays pending while asserted regardless of W1C.
  - Changing INVERT or EDGE does not clear sticky. An INVERT toggle can create an edge; that edge is captured.
- Write FSM, states W_IDLE, W_BURST, W_RESP:
  - In W_IDLE, o_awready=o_wready=1 only when i_awvalid & i_wvalid in the same cycle (joint accept).
  - awlen==0: perform the write, go to W_RESP with bresp=OKAY, bid=awid.
  - awlen!=0: first beat is not written; go to W_BURST, keep wready=1, drain beats until wlast, then W_RESP with bresp=SLVERR (2'b10).
  - W_RESP: bvalid=1 until i_bready, then W_IDLE. bvalid asserts the cycle after the final accepted beat.
- Read FSM, states R_IDLE, R_DATA:
  - In R_IDLE, arready=1 when arvalid. Capture id, len and register data; next cycle rvalid=1.
  - arlen==0: one beat, OKAY, rlast=1.
  - arlen!=0: arlen+1 beats of zero data, rresp=SLVERR, rlast on the final beat. A beat counter advances on rvalid & rready.
  - Return to R_IDLE after the last beat handshakes.
  - rdata is held stable while rvalid & ~rready.
- Read and write FSMs are independent. A read captured in the same cycle as a write commits returns the pre-write value.
- awsize, awburst and arburst are not checked. Narrow accesses are governed by wstrb only.
- Reset mid-transaction aborts immediately. No response is issued after reset deassertion.

Decomposition:
- Package axi_irq_pkg: register index constants (REG_RAW..REG_SWSET), RESP_OKAY/RESP_SLVERR, write and read FSM state enums.
- Sub-module irq_src_cell: one per source, via generate. Contains synchroniser, polarity, edge detect, sticky bit and W1C/SWSET inputs; outputs raw and pending. The top holds the AXI FSMs and the ENABLE/EDGE/INVERT registers.

Test Plan:
- Reset, then read all 8 registers -> all rdata=0 with OKAY, o_irq=0.
- Set ENABLE=0xFF, EDGE=0 and drive i_irq[2]=1 -> o_irq=0x04 exactly 3 cycles later (SYNC_STAGES=2). Drop the input -> o_irq=0 after 3 cycles. W1C 0x04 while the input is high -> PENDING stays 0x04.
- Set EDGE=0x01 and pulse i_irq[0] for 1 cycle -> PENDING=0x01 sticky and o_irq[0]=1. Write PENDING=0x01 -> o_irq[0]=0 next cycle. Repeat with the second pulse's edge landing in the W1C cycle -> PENDING=0x01 (set wins).
- Set INVERT=0x80 with i_irq[7]=0 -> RAW reads 0x80. Write SWSET=0x40 with EDGE=0x40 -> PENDING=0x40 and RAW is unchanged.
- Write burst awlen=3 -> 4 W beats accepted, then bresp=SLVERR with bid echoed; no register changed. Read burst arlen=2 -> 3 beats of zero data with SLVERR and rlast on beat 3.
- Hold i_bready=0 and i_rready=0 for 5 cycles -> bvalid/rvalid and data stay stable. No new AW or AR is accepted until the handshake completes.
